// File: rtl/sram_pkg.sv
// Shared definitions for the 256x16 SRAM: default geometry and control-mode decode.
package sram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;

  // Bus modes decoded from the active-low control strobes.
  typedef enum logic [1:0] {
    DESELECT,
    WRITE,
    READ,
    OUT_DIS
  } mode_e;

  // Write wins over output_enable. Chip deselect wins over everything.
  function automatic mode_e decode_mode(input logic ce_n,
                                        input logic we_n,
                                        input logic oe_n);
    if (ce_n)  return DESELECT;
    if (!we_n) return WRITE;
    if (!oe_n) return READ;
    return OUT_DIS;
  endfunction

endpackage

// File: rtl/sram_256x16.sv
// Single-port SRAM with synchronous write, asynchronous read and a shared tri-state data bus.
module sram_256x16
  import sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  input  logic              chip_enable,
  input  logic              write_enable,
  input  logic              output_enable
);

  localparam logic [ADDR_W:0] DEPTH_CMP = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  mode_e             mode;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;

  // Decode the bus mode and address validity from the current controls.
  always_comb begin
    mode     = decode_mode(chip_enable, write_enable, output_enable);
    in_range = ({1'b0, address} < DEPTH_CMP);
  end

  // Storage array: cleared asynchronously on reset, written on the rising edge in WRITE mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mode == WRITE && in_range) begin
      mem[address] <= data;
    end
  end

  // Asynchronous read path. Out-of-range addresses read as zero.
  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = mem[address];
    end
  end

  // The bus is driven only during a READ outside reset; it is released in every other mode.
  assign data = (reset && mode == READ) ? rd_word : 'z;

endmodule

// File: tb/tb_sram_256x16.sv
// Self-checking bench for sram_256x16 against a word-array reference model.
module tb_sram_256x16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  address;
  logic        chip_enable;
  logic        write_enable;
  logic        output_enable;
  logic [15:0] tb_drive;
  logic        tb_oe;
  wire  [15:0] data;

  int checks = 0;
  int passed = 0;

  logic [15:0] model [256];

  always #5 clk = ~clk;

  assign data = tb_oe ? tb_drive : 'z;

  sram_256x16 #(
    .ADDR_W(8),
    .DATA_W(16),
    .DEPTH (256)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .data         (data),
    .chip_enable  (chip_enable),
    .write_enable (write_enable),
    .output_enable(output_enable)
  );

  task automatic idle();
    chip_enable   = 1'b1;
    write_enable  = 1'b1;
    output_enable = 1'b1;
    tb_oe         = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
  endtask

  // One write on the next rising edge; controls stay asserted so calls chain back to back.
  task automatic write_word(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    address       = a;
    tb_drive      = d;
    tb_oe         = 1'b1;
    chip_enable   = 1'b0;
    write_enable  = 1'b0;
    output_enable = 1'b1;
    @(posedge clk);
    if (reset) model[a] = d;
    #1;
  endtask

  task automatic end_write();
    @(negedge clk);
    idle();
  endtask

  task automatic read_check(input logic [7:0] a, input string name);
    tb_oe         = 1'b0;
    chip_enable   = 1'b0;
    write_enable  = 1'b1;
    output_enable = 1'b0;
    address       = a;
    #1;
    checks++;
    if (data !== model[a])
      $display("FAIL %s addr=%h got=%h expected=%h", name, a, data, model[a]);
    else
      passed++;
  endtask

  // A released bus reads as Z (or as 0 on a two-state simulator); never as the stored word.
  task automatic release_check(input string name);
    #1;
    checks++;
    if (data !== 16'hzzzz && data !== 16'h0000)
      $display("FAIL %s got=%h expected=released", name, data);
    else
      passed++;
  endtask

  task automatic test_reset();
    idle();
    address  = 8'h00;
    tb_drive = 16'h0000;
    reset    = 1'b1;
    #2;
    reset = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    read_check(8'h00, "reset_0x00");
    read_check(8'h7F, "reset_0x7F");
    read_check(8'hFF, "reset_0xFF");
  endtask

  task automatic test_write_read();
    write_word(8'h10, 16'hA5C3);
    end_write();
    read_check(8'h10, "wr_rd_0x10");
    read_check(8'h11, "wr_rd_0x11");
  endtask

  task automatic test_async_reset();
    write_word(8'h20, 16'h7777);
    end_write();
    read_check(8'h20, "pre_reset_0x20");
    @(negedge clk);
    #2;
    reset = 1'b0;
    clear_model();
    write_word(8'h30, 16'h9999);
    end_write();
    reset = 1'b1;
    read_check(8'h10, "async_rst_0x10");
    read_check(8'h20, "async_rst_0x20");
    read_check(8'h30, "write_in_reset_0x30");
  endtask

  task automatic test_burst();
    for (int i = 0; i < 16; i++) write_word(8'(i), 16'(i + 1));
    end_write();
    for (int i = 0; i < 16; i++) read_check(8'(i), "burst_readback");
    write_word(8'hFF, 16'hBEEF);
    write_word(8'h00, 16'h1234);
    end_write();
    read_check(8'h00, "alias_0x00");
    read_check(8'hFF, "alias_0xFF");
    read_check(8'h01, "alias_0x01");
  endtask

  task automatic test_bus_release();
    write_word(8'h40, 16'hAAAA);
    end_write();
    read_check(8'h40, "release_setup");
    @(negedge clk);
    chip_enable = 1'b1; write_enable = 1'b1; output_enable = 1'b0; address = 8'h40;
    release_check("release_deselect");
    chip_enable = 1'b0; write_enable = 1'b1; output_enable = 1'b1;
    release_check("release_oe_off");
    @(negedge clk);
    tb_drive = 16'h5555; tb_oe = 1'b1;
    chip_enable = 1'b0; write_enable = 1'b0; output_enable = 1'b0;
    #1;
    checks++;
    if (data !== 16'h5555)
      $display("FAIL release_write_contention got=%h expected=5555", data);
    else
      passed++;
    @(posedge clk);
    model[8'h40] = 16'h5555;
    end_write();
    read_check(8'h40, "write_with_oe_low");
  endtask

  task automatic test_glitch();
    @(negedge clk);
    address = 8'h05; tb_drive = 16'hDEAD; tb_oe = 1'b1;
    chip_enable = 1'b1; write_enable = 1'b0; output_enable = 1'b1;
    @(posedge clk);
    end_write();
    read_check(8'h05, "glitch_no_write");
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [15:0] d;
    for (int n = 0; n < 300; n++) begin
      a = 8'($urandom_range(0, 255));
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0: begin write_word(a, d); end_write(); end
        1: begin
             read_check(a, "rand_read");
             read_check(~a, "rand_read_same_cycle");
           end
        2: begin
             @(negedge clk);
             address = a; tb_drive = d; tb_oe = 1'b1;
             chip_enable = 1'b1; write_enable = 1'b0; output_enable = 1'b0;
             @(posedge clk);
             end_write();
             read_check(a, "rand_deselect_write");
           end
        default: begin
             for (int k = 0; k < 3; k++) write_word(8'(a + k), d ^ 16'(k));
             end_write();
             read_check(a + 8'd1, "rand_burst");
           end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_async_reset();
    test_burst();
    test_bus_release();
    test_glitch();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
